// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module   : fetch_stage_if
// Brief    : Decode-redirect, instruction-memory and IF/ID bundle for
//            fetch_stage. Optional perf ports under FETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if;
  logic        id_if_selpcsource;
  logic [1:0]  id_if_selpctype;
  logic [31:0] id_if_pcimd2ext;
  logic [31:0] id_if_rega;
  logic [31:0] id_if_pcindex;
  logic        if_mem_req;
  logic [31:0] if_mem_addr;
  logic        mem_if_ready;
  logic [31:0] mem_if_data;
  logic [31:0] if_id_instruc;
  logic [31:0] if_id_nextpc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] if_perf_fetches;
  logic [31:0] if_perf_stalls;
`endif

  modport master (
    input  id_if_selpcsource, id_if_selpctype, id_if_pcimd2ext,
    input  id_if_rega, id_if_pcindex, mem_if_ready, mem_if_data,
    output if_mem_req, if_mem_addr, if_id_instruc, if_id_nextpc
`ifdef FETCH_PERF_CNT_EN
    , output if_perf_fetches, if_perf_stalls
`endif
  );

  modport slave (
    output id_if_selpcsource, id_if_selpctype, id_if_pcimd2ext,
    output id_if_rega, id_if_pcindex, mem_if_ready, mem_if_data,
    input  if_mem_req, if_mem_addr, if_id_instruc, if_id_nextpc
`ifdef FETCH_PERF_CNT_EN
    , input if_perf_fetches, if_perf_stalls
`endif
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : MIPS instruction-fetch stage: PC, memory req/ready handshake,
//            IF/ID register, branch/jump redirects with one delay slot.
//            Optional counters enabled by defining FETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  wire logic     clock,
  input  wire logic     reset,
  fetch_stage_if.master bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_pc;
  logic [31:0] r_redir_pc;
  logic        r_redir_pending;
  logic [31:0] r_instruc;
  logic [31:0] r_nextpc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetches;
  logic [31:0] r_perf_stalls;
`endif

  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;

  always_comb begin
    w_target = bus.id_if_pcimd2ext;
    case (bus.id_if_selpctype)
      2'b01:   w_target = bus.id_if_rega;
      2'b10:   w_target = bus.id_if_pcindex;
      default: w_target = bus.id_if_pcimd2ext;
    endcase
  end

  assign w_pc_plus4 = r_pc + 32'd4;

  // A same-cycle redirect beats one latched while the delay slot was stalled.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (bus.id_if_selpcsource)
      w_next_pc = w_target;
    else if (r_redir_pending)
      w_next_pc = r_redir_pc;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_req           <= 1'b0;
      r_pc            <= RESET_PC;
      r_redir_pc      <= 32'h0000_0000;
      r_redir_pending <= 1'b0;
      r_instruc       <= NOP_WORD;
      r_nextpc        <= 32'h0000_0000;
`ifdef FETCH_PERF_CNT_EN
      r_perf_fetches  <= 32'h0000_0000;
      r_perf_stalls   <= 32'h0000_0000;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
        S_FETCH: begin
          if (bus.mem_if_ready) begin
            r_instruc       <= bus.mem_if_data;
            r_nextpc        <= w_pc_plus4;
            r_pc            <= w_next_pc;
            r_redir_pending <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            r_perf_fetches  <= r_perf_fetches + 32'd1;
`endif
          end else begin
            r_instruc <= NOP_WORD;
            if (bus.id_if_selpcsource) begin
              r_redir_pc      <= w_target;
              r_redir_pending <= 1'b1;
            end
`ifdef FETCH_PERF_CNT_EN
            r_perf_stalls <= r_perf_stalls + 32'd1;
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_mem_req    = r_req;
  assign bus.if_mem_addr   = r_pc;
  assign bus.if_id_instruc = r_instruc;
  assign bus.if_id_nextpc  = r_nextpc;
`ifdef FETCH_PERF_CNT_EN
  assign bus.if_perf_fetches = r_perf_fetches;
  assign bus.if_perf_stalls  = r_perf_stalls;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Randomized self-checking bench for fetch_stage against a
//            fetch-address-sequence reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;
  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] C_NOP      = 32'h0000_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(C_RESET_PC), .NOP_WORD(C_NOP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign bus.mem_if_data = mem_word(bus.if_mem_addr);

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: m_addr is the fetch in flight; m_after is the address that
  // must follow it when a redirect landed while it was stalled.
  bit          m_fetch;
  logic [31:0] m_addr, m_instr, m_nextpc, m_after;
  bit          m_has_after;
  logic [31:0] m_fetches, m_stalls;

  task automatic model_reset();
    m_fetch = 0; m_addr = C_RESET_PC; m_instr = C_NOP; m_nextpc = 0;
    m_has_after = 0; m_after = 0; m_fetches = 0; m_stalls = 0;
  endtask

  task automatic check_all();
    check_val("req",    {31'd0, bus.if_mem_req}, {31'd0, m_fetch});
    check_val("addr",   bus.if_mem_addr,   m_addr);
    check_val("instr",  bus.if_id_instruc, m_instr);
    check_val("nextpc", bus.if_id_nextpc,  m_nextpc);
`ifdef FETCH_PERF_CNT_EN
    check_val("perf_fetches", bus.if_perf_fetches, m_fetches);
    check_val("perf_stalls",  bus.if_perf_stalls,  m_stalls);
`endif
  endtask

  task automatic do_cycle(input bit rdy, input bit sel, input logic [1:0] typ,
                          input logic [31:0] tgt);
    bus.mem_if_ready      = rdy;
    bus.id_if_selpcsource = sel;
    bus.id_if_selpctype   = typ;
    bus.id_if_pcimd2ext   = $urandom();
    bus.id_if_rega        = $urandom();
    bus.id_if_pcindex     = $urandom();
    case (typ)
      2'b01:   bus.id_if_rega      = tgt;
      2'b10:   bus.id_if_pcindex   = tgt;
      default: bus.id_if_pcimd2ext = tgt;
    endcase
    if (!m_fetch) begin
      m_fetch = 1;
    end else if (rdy) begin
      m_instr  = mem_word(m_addr);
      m_nextpc = m_addr + 32'd4;
      m_addr   = sel ? tgt : (m_has_after ? m_after : m_addr + 32'd4);
      m_has_after = 0;
      m_fetches++;
    end else begin
      m_instr = C_NOP;
      if (sel) begin m_after = tgt; m_has_after = 1; end
      m_stalls++;
    end
    @(posedge clock);
    #1;
    check_all();
  endtask

  initial begin
    bus.mem_if_ready = 0; bus.id_if_selpcsource = 0; bus.id_if_selpctype = 0;
    bus.id_if_pcimd2ext = 0; bus.id_if_rega = 0; bus.id_if_pcindex = 0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 0;
    #1;
    check_all();

    // Idle cycle then zero-wait stream.
    for (int i = 0; i < 7; i++) do_cycle(1, 0, 2'b00, 0);
    // Two wait states per fetch.
    for (int i = 0; i < 4; i++) begin
      do_cycle(0, 0, 2'b00, 0);
      do_cycle(0, 0, 2'b00, 0);
      do_cycle(1, 0, 2'b00, 0);
    end
    // Branch with zero wait; delay slot then target.
    do_cycle(1, 1, 2'b00, 32'h40);
    for (int i = 0; i < 3; i++) do_cycle(1, 0, 2'b00, 0);
    // Jump-register while delay slot is stalled.
    do_cycle(0, 1, 2'b01, 32'h100);
    do_cycle(1, 0, 2'b00, 0);
    do_cycle(1, 0, 2'b00, 0);
    // Jump to top of address space and wrap.
    do_cycle(1, 1, 2'b10, 32'hFFFF_FFFC);
    do_cycle(1, 0, 2'b00, 0);
    do_cycle(1, 0, 2'b00, 0);
    do_cycle(1, 0, 2'b11, 0);

    // Random traffic with legal redirects.
    for (int i = 0; i < 400; i++) begin
      bit r, s;
      r = ($urandom_range(0, 3) != 0);
      s = m_fetch && !m_has_after && ($urandom_range(0, 7) == 0);
      do_cycle(r, s, 2'($urandom_range(0, 3)), $urandom());
    end

    // Reset in the middle of a stalled fetch with a redirect pending.
    do_cycle(0, 1, 2'b00, 32'h200);
    bus.id_if_selpcsource = 0;
    #2;
    reset = 1;
    bus.mem_if_ready = 1;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    reset = 0;
    for (int i = 0; i < 5; i++) do_cycle(1, 0, 2'b00, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Holds the PC and drives a req/ready handshake to instruction memory.
- Loads the IF/ID pipeline register (instruction + PC+4) and applies redirects from decode: branch, jump, jump-register.
- Architectural branch delay slot: the instruction after a branch is always executed and never flushed.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_if_selpcsource  in  1  1 = redirect the PC this cycle.
- id_if_selpctype  in  2  redirect source: 00 = id_if_pcimd2ext, 01 = id_if_rega, 10 = id_if_pcindex, 11 = id_if_pcimd2ext.
- id_if_pcimd2ext  in  32  branch target.
- id_if_rega  in  32  jump-register target.
- id_if_pcindex  in  32  jump target.
- if_mem_req  out  1  instruction-memory request.
- if_mem_addr  out  32  fetch address.
- mem_if_ready  in  1  read data valid; completes the request.
- mem_if_data  in  32  instruction word.
- if_id_instruc  out  32  IF/ID instruction register.
- if_id_nextpc  out  32  IF/ID PC+4 register.

Behaviour:
- Reset (asynchronous, active-high):
  - pc = RESET_PC; state = S_IDLE; redir_pc = 0; redir_pending = 0.
  - if_id_instruc = NOP_WORD; if_id_nextpc = 0.
  - if_mem_req = 0; if_mem_addr = RESET_PC.
- State machine:
  - S_IDLE: if_mem_req = 0. Occupies exactly one cycle after reset deasserts, then goes to S_FETCH.
  - S_FETCH: if_mem_req = 1 and if_mem_addr = pc, held stable until mem_if_ready.
    - On a cycle with mem_if_ready = 1: if_id_instruc <= mem_if_data; if_id_nextpc <= pc + 4.
    - pc <= next_pc (below). Stay in S_FETCH.
    - A back-to-back request is issued on the following cycle, so throughput is 1 instruction/cycle with zero-wait memory.
  - On a S_FETCH cycle with mem_if_ready = 0: if_id_instruc <= NOP_WORD; if_id_nextpc holds its value; pc holds.
- Redirect target: target = mux(id_if_selpctype) as listed under Ports, evaluated combinationally in the same cycle.
- next_pc priority on a ready cycle:
  1. id_if_selpcsource = 1 → target.
  2. Otherwise redir_pending = 1 → redir_pc, and redir_pending clears.
  3. Otherwise pc + 4.
- Redirect arriving while not ready (id_if_selpcsource = 1, mem_if_ready = 0): redir_pc <= target; redir_pending <= 1.
  - The outstanding fetch at pc is the delay slot and completes normally.
- Each decode instruction is presented for exactly one cycle, so at most one redirect is pending at a time.
- A new redirect while redir_pending = 1 overwrites redir_pc. This cannot occur in legal code, since bubbles separate the instructions.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0. Address bits [1:0] are driven as-is; no alignment check.
- Redirect inputs are ignored in S_IDLE.
- Reset asserted mid-request: if_mem_req drops immediately (asynchronously). Any late mem_if_ready is ignored until S_FETCH is re-entered.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs if_perf_fetches [31:0] and if_perf_stalls [31:0], both reset to 0.
  - if_perf_fetches increments on each completed fetch.
  - if_perf_stalls increments on each S_FETCH cycle with mem_if_ready = 0.
  - Both counters wrap at 2^32.
- Undefined: neither port nor counter logic exists.

Test Plan:
- Zero-wait memory (mem_if_ready tied 1), RESET_PC = 0:
  - S_IDLE cycle, then addresses 0, 4, 8, 12 on consecutive cycles.
  - if_id_nextpc follows 4, 8, 12, 16 one cycle after each address.
  - if_id_instruc matches the memory words.
- Memory with 2 wait states:
  - Each address is held for 3 cycles with if_mem_req = 1.
  - if_id_instruc = NOP_WORD for 2 cycles, then the fetched word.
  - With FETCH_PERF_CNT_EN: if_perf_stalls = 2 per fetch.
- Branch at 0x10, zero wait, id_if_selpcsource = 1, selpctype = 00, pcimd2ext = 0x40:
  - Fetch sequence 0x10, 0x14 (delay slot), 0x40, 0x44.
- Jump-register with 1 wait state: selpcsource = 1, selpctype = 01, rega = 0x100, while the 0x14 fetch is stalled:
  - redir_pending set; 0x14 completes; next address 0x100.
- Wrap: pc = 0xFFFF_FFFC, no redirect → if_id_nextpc = 0, next address 0x0.
- Reset asserted while if_mem_req = 1 with a pending redirect:
  - if_mem_req = 0 immediately; if_id_instruc = NOP_WORD.
  - After deassert: one idle cycle, then fetch from RESET_PC; the pending redirect is discarded.
